reg_pipe: RTL and testbench
===========================

REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data bits per word.
REQ-002 SHALL have parameter NUM_PORTS, default 2, legal 1..8, meaning independent output channels.
REQ-003 SHALL have parameter DEPTH, default 2, legal 1..16, meaning pipeline stages per channel.
REQ-004 SHALL have port clk  input  1  rising-edge clock; the single clock of the block.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port load  input  1  capture data_in into the hold register.
REQ-007 SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-008 SHALL have port flush  input  1  synchronous invalidate of all held/pipelined data.
REQ-009 SHALL have port stall  input  NUM_PORTS  per-channel freeze, bit p for channel p.
REQ-010 SHALL have port data_out  output  NUM_PORTS*DATA_WIDTH  channel p at bits [p*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port valid_out  output  NUM_PORTS  bit p is high when data_out channel p holds loaded data.
REQ-012 SHALL have port hold_q  output  DATA_WIDTH  current hold-register contents.

Function
REQ-013 SHALL keep one hold register (hold, hold_valid); on a clock edge with load=1: hold <= data_in, hold_valid <= 1.
REQ-014 SHALL, with load=0 and flush=0, leave hold and hold_valid unchanged.
REQ-015 SHALL give each channel a DEPTH-stage shift chain of {data, valid}; stage 0 input = load ? {data_in,1} : {hold,hold_valid}.
REQ-016 SHALL, with stall[p]=0, shift every stage of channel p by one per edge; with stall[p]=1, hold all stages of channel p unchanged.
REQ-017 SHALL drive data_out/valid_out channel p from stage DEPTH-1 of channel p, registered, with no combinational path from inputs.
REQ-018 SHALL give latency: load sampled at edge t with no stall -> data_out valid after edge t+DEPTH-1 (DEPTH cycles); each stalled cycle adds one.
REQ-019 SHALL recirculate hold into every unstalled chain each cycle, so outputs remain at the last loaded value indefinitely.
REQ-020 SHALL, on flush=1 at an edge, clear the valid bit of every stage of every channel (stall ignored) and keep stage data bits unchanged.
REQ-021 SHALL, on flush=1 with load=0, clear hold_valid; with flush=1 and load=1, load hold <= data_in, hold_valid <= 1; pipeline valids still clear.
REQ-022 SHALL operate channels independently; stall on one channel SHALL NOT affect timing of any other.
REQ-023 SHALL, for DEPTH=1, register stage 0 directly onto data_out (latency 1 cycle).

Reset
REQ-024 SHALL, while reset=0, immediately (without clk) force hold_q, hold_valid, all stage data, data_out and valid_out to 0.
REQ-025 SHALL apply reset mid-stall or mid-flush identically; the first edge after reset deassertion behaves as a normal cycle.

Verification (DATA_WIDTH=32, NUM_PORTS=2, DEPTH=3)
REQ-026 SHALL cover: reset=0 asserted between edges during traffic -> data_out=0, valid_out=2'b00, hold_q=0 immediately.
REQ-027 SHALL cover: load=1 one cycle with 0xA5A50001 at edge t, stall=0 -> both channels 0xA5A50001 with valid_out=2'b11 after edge t+2, held thereafter.
REQ-028 SHALL cover: after REQ-027, load 0x00000002 at edge t, stall[1]=1 for edges t+1 and t+2 -> channel0 shows 2 after t+2; channel1 shows 1 until after t+4, then 2.
REQ-029 SHALL cover: flush=1 one cycle at edge t while valid -> valid_out=2'b00 after t and stays 0 until next load; data_out bits unchanged.
REQ-030 SHALL cover: flush=1 and load=1 with 0x00000003 at edge t -> valid_out=0 after t and t+1; after t+3 both channels 3, valid_out=2'b11; hold_q=3 after t.
REQ-031 SHALL cover: DEPTH=1 build, load 0xFFFFFFFF at edge t -> data_out=0xFFFFFFFF, valid_out=1 after edge t.

Source files
------------

// File: rtl/reg_pipe.sv
// Hold register feeding NUM_PORTS independent DEPTH-stage shift chains.
// Unstalled chains recirculate the hold value, so outputs settle on the last load.
module reg_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 2,
  parameter int DEPTH      = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            load,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            flush,
  input  logic [NUM_PORTS-1:0]            stall,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out,
  output logic [NUM_PORTS-1:0]            valid_out,
  output logic [DATA_WIDTH-1:0]           hold_q
);

  logic [DATA_WIDTH-1:0] hold_d;
  logic                  hold_valid_q;
  logic                  hold_valid_d;

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (load) begin
      hold_d       = data_in;
      hold_valid_d = 1'b1;
    end else if (flush) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_chan
      logic [DEPTH-1:0][DATA_WIDTH-1:0] stage_data_q;
      logic [DEPTH-1:0][DATA_WIDTH-1:0] stage_data_d;
      logic [DEPTH-1:0]                 stage_valid_q;
      logic [DEPTH-1:0]                 stage_valid_d;

      // Flush wins over stall and freezes data; only the valid bits drop.
      always_comb begin
        stage_data_d  = stage_data_q;
        stage_valid_d = stage_valid_q;
        if (flush) begin
          stage_valid_d = '0;
        end else if (!stall[gi]) begin
          stage_data_d[0]  = load ? data_in : hold_q;
          stage_valid_d[0] = load | hold_valid_q;
          for (int s = 1; s < DEPTH; s++) begin
            stage_data_d[s]  = stage_data_q[s-1];
            stage_valid_d[s] = stage_valid_q[s-1];
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          stage_data_q  <= '0;
          stage_valid_q <= '0;
        end else begin
          stage_data_q  <= stage_data_d;
          stage_valid_q <= stage_valid_d;
        end
      end

      // The last stage is itself the output register.
      assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] = stage_data_q[DEPTH-1];
      assign valid_out[gi]                         = stage_valid_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: tb/tb_reg_pipe.sv
// Directed plus randomized checks of reg_pipe (32b x 2 channels x 3 stages, and a
// 1-channel 1-stage build) against a queue-based behavioural model.
module tb_reg_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data_in = '0;
  logic        flush = 1'b0;
  logic [1:0]  stall = '0;
  logic [63:0] data_out;
  logic [1:0]  valid_out;
  logic [31:0] hold_q;
  logic [0:0]  stall1;
  logic [31:0] data_out1;
  logic [0:0]  valid_out1;
  logic [31:0] hold_q1;

  int checks = 0;
  int errors = 0;

  // Model: each chain is a queue of {valid,data}, newest at the front.
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [32:0] qd[$];
  logic [31:0] m_hold;
  logic        m_hold_v;

  assign stall1 = stall[0:0];

  always #5 clk = ~clk;

  reg_pipe #(.DATA_WIDTH(32), .NUM_PORTS(2), .DEPTH(3)) dut (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in), .flush(flush),
    .stall(stall), .data_out(data_out), .valid_out(valid_out), .hold_q(hold_q)
  );

  reg_pipe #(.DATA_WIDTH(32), .NUM_PORTS(1), .DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in), .flush(flush),
    .stall(stall1), .data_out(data_out1), .valid_out(valid_out1), .hold_q(hold_q1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); qd.delete();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(33'h0);
      q1.push_back(33'h0);
    end
    qd.push_back(33'h0);
    m_hold   = '0;
    m_hold_v = 1'b0;
  endtask

  task automatic model_edge();
    logic [32:0] ent;
    ent = load ? {1'b1, data_in} : {m_hold_v, m_hold};
    if (flush) begin
      foreach (q0[i]) q0[i] = q0[i] & 33'h0_FFFF_FFFF;
      foreach (q1[i]) q1[i] = q1[i] & 33'h0_FFFF_FFFF;
      foreach (qd[i]) qd[i] = qd[i] & 33'h0_FFFF_FFFF;
    end else begin
      if (!stall[0]) begin q0.push_front(ent); void'(q0.pop_back()); end
      if (!stall[1]) begin q1.push_front(ent); void'(q1.pop_back()); end
      if (!stall[0]) begin qd.push_front(ent); void'(qd.pop_back()); end
    end
    if (load) begin
      m_hold   = data_in;
      m_hold_v = 1'b1;
    end else if (flush) begin
      m_hold_v = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    logic [32:0] e0, e1, ed;
    e0 = q0[q0.size()-1];
    e1 = q1[q1.size()-1];
    ed = qd[qd.size()-1];
    chk({tag, ".data_out"},  {32'h0, data_out[63:32], data_out[31:0]} & 64'hFFFF_FFFF_FFFF_FFFF,
        {e1[31:0], e0[31:0]});
    chk({tag, ".valid_out"}, {62'h0, valid_out}, {62'h0, e1[32], e0[32]});
    chk({tag, ".hold_q"},    {32'h0, hold_q},    {32'h0, m_hold});
    chk({tag, ".d1_data"},   {32'h0, data_out1}, {32'h0, ed[31:0]});
    chk({tag, ".d1_valid"},  {63'h0, valid_out1}, {63'h0, ed[32]});
  endtask

  // One clock edge: update the model with the applied inputs, then check after the edge.
  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
    $display("%0t %s load=%0b din=%h flush=%0b stall=%b -> out=%h vld=%b hold=%h",
             $time, tag, load, data_in, flush, stall, data_out, valid_out, hold_q);
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, ".rst_data"},  data_out, 64'h0);
    chk({tag, ".rst_valid"}, {62'h0, valid_out}, 64'h0);
    chk({tag, ".rst_hold"},  {32'h0, hold_q}, 64'h0);
    chk({tag, ".rst_d1"},    {31'h0, valid_out1, data_out1}, 64'h0);
  endtask

  initial begin
    model_reset();
    #3;
    check_reset_zero("init");
    @(negedge clk);
    reset = 1'b1;

    // Single load propagates to both channels after two further edges.
    load = 1'b1; data_in = 32'hA5A5_0001;
    cyc("l1_t0");
    chk("d1_ffload", {31'h0, valid_out1, data_out1}, {31'h0, 1'b1, 32'hA5A5_0001});
    load = 1'b0; data_in = $urandom;
    cyc("l1_t1");
    chk("l1_not_yet", {62'h0, valid_out}, 64'h0);
    cyc("l1_t2");
    chk("l1_arrive", data_out, 64'hA5A5_0001_A5A5_0001);
    chk("l1_valid", {62'h0, valid_out}, 64'h3);
    for (int i = 0; i < 3; i++) cyc("l1_hold");
    chk("l1_held", data_out, 64'hA5A5_0001_A5A5_0001);

    // Channel 1 stalled for two edges lags by exactly two cycles.
    load = 1'b1; data_in = 32'h0000_0002;
    cyc("st_t0");
    load = 1'b0; stall = 2'b10;
    cyc("st_t1");
    cyc("st_t2");
    chk("st_ch0_new", {32'h0, data_out[31:0]}, 64'h2);
    chk("st_ch1_old", {32'h0, data_out[63:32]}, 64'hA5A5_0001);
    stall = 2'b00;
    cyc("st_t3");
    chk("st_ch1_still", {32'h0, data_out[63:32]}, 64'hA5A5_0001);
    cyc("st_t4");
    chk("st_ch1_new", {32'h0, data_out[63:32]}, 64'h2);

    // Flush drops valids but leaves data in place.
    flush = 1'b1; stall = 2'b01;
    cyc("fl_t0");
    chk("fl_valid", {62'h0, valid_out}, 64'h0);
    chk("fl_data", data_out, 64'h0000_0002_0000_0002);
    flush = 1'b0; stall = 2'b00;
    for (int i = 0; i < 4; i++) cyc("fl_idle");
    chk("fl_stay", {62'h0, valid_out}, 64'h0);

    // Flush with load: hold reloads, pipeline restarts from empty.
    flush = 1'b1; load = 1'b1; data_in = 32'h0000_0003;
    cyc("fll_t0");
    chk("fll_hold", {32'h0, hold_q}, 64'h3);
    chk("fll_v0", {62'h0, valid_out}, 64'h0);
    flush = 1'b0; load = 1'b0;
    cyc("fll_t1");
    chk("fll_v1", {62'h0, valid_out}, 64'h0);
    cyc("fll_t2");
    cyc("fll_t3");
    chk("fll_arrive", data_out, 64'h0000_0003_0000_0003);
    chk("fll_valid", {62'h0, valid_out}, 64'h3);

    // Depth-1 build: one edge of latency.
    load = 1'b1; data_in = 32'hFFFF_FFFF;
    cyc("d1_t0");
    chk("d1_all1", {31'h0, valid_out1, data_out1}, {31'h0, 1'b1, 32'hFFFF_FFFF});
    load = 1'b0;

    // Asynchronous reset between edges during traffic.
    cyc("ar_pre");
    #2;
    reset = 1'b0;
    #1;
    check_reset_zero("ar_mid");
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic, with occasional mid-cycle resets.
    for (int n = 0; n < 400; n++) begin
      load    = ($urandom_range(0, 99) < 30);
      data_in = $urandom;
      flush   = ($urandom_range(0, 99) < 6);
      stall   = {($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 30)};
      cyc("rnd");
      if ($urandom_range(0, 99) < 3) begin
        reset = 1'b0;
        #1;
        check_reset_zero("rnd_rst");
        model_reset();
        #1;
        reset = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
